// File: rtl/blk_ram_if.sv
// Block-RAM bus: command side driven by the master, read data and status
// returned by the slave.
interface blk_ram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DATAI;
  logic [DATA_W-1:0] DATAO;
  logic              DVALID;
  logic              BUSY;
  logic              ERR;

  modport master (
    output READ, WRITE, ADDR, DATAI,
    input  DATAO, DVALID, BUSY, ERR
  );

  modport slave (
    input  READ, WRITE, ADDR, DATAI,
    output DATAO, DVALID, BUSY, ERR
  );
endinterface

// File: rtl/blk_ram_slv.sv
// Single-port block-RAM responder. Zeroes the array after reset (optional),
// then serves READ/WRITE commands; read data returns RD_LAT cycles after the
// command edge (RD_LAT must be 1 or 2). A simultaneous READ+WRITE performs the
// write, drops the read and flags ERR; commands during the clear are refused
// and flagged.
module blk_ram_slv #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input logic     CLK,
  input logic     RST_N,
  blk_ram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? S_CLEAR : S_READY;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rd_acc;
  logic [RD_LAT-1:0]   rd_vld_q;
  logic [DATA_W-1:0]   rd_data_q [RD_LAT];
  logic [DATA_W-1:0]   datao_q;
  logic                dvalid_q;

  // Next state, array write port selection, read acceptance and error flag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.ADDR;
    mem_wdata = bus.DATAI;
    rd_acc    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        // The clear owns the write port; any bus command is refused.
        mem_we    = RST_N;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        err_d     = bus.READ | bus.WRITE;
        if (&cnt_q) state_d = S_READY;
      end
      S_READY: begin
        // On a collision the write wins and the read is discarded.
        mem_we = RST_N & bus.WRITE;
        rd_acc = bus.READ & ~bus.WRITE;
        err_d  = bus.READ & bus.WRITE;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // State, clear counter and error pulse registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage array write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read valid pipeline, flushed immediately by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= rd_acc;
      for (int i = 1; i < RD_LAT; i++) rd_vld_q[i] <= rd_vld_q[i-1];
    end
  end

  // Read data pipeline travelling alongside the valid bits
  always_ff @(posedge CLK) begin
    if (rd_acc) rd_data_q[0] <= mem_q[bus.ADDR];
    for (int i = 1; i < RD_LAT; i++) rd_data_q[i] <= rd_data_q[i-1];
  end

  // Output registers; DATAO only changes when a read word is returned
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      datao_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= rd_vld_q[RD_LAT-1];
      if (rd_vld_q[RD_LAT-1]) datao_q <= rd_data_q[RD_LAT-1];
    end
  end

  assign bus.DATAO  = datao_q;
  assign bus.DVALID = dvalid_q;
  assign bus.BUSY   = (state_q == S_CLEAR);
  assign bus.ERR    = err_q;
endmodule

// File: tb/tb_blk_ram_slv.sv
// Bench for blk_ram_slv: RD_LAT=1 and RD_LAT=2 instances driven with the same
// command stream, plus a CLR_ON_RST=0 instance checked for its reset state.
module tb_blk_ram_slv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] mem_m [256];

  always #5 clk = ~clk;

  blk_ram_if #(.ADDR_W(8), .DATA_W(16)) b1 ();
  blk_ram_if #(.ADDR_W(8), .DATA_W(16)) b2 ();
  blk_ram_if #(.ADDR_W(8), .DATA_W(16)) b3 ();

  assign b2.READ  = b1.READ;
  assign b2.WRITE = b1.WRITE;
  assign b2.ADDR  = b1.ADDR;
  assign b2.DATAI = b1.DATAI;
  assign b3.READ  = 1'b0;
  assign b3.WRITE = 1'b0;
  assign b3.ADDR  = 8'h00;
  assign b3.DATAI = 16'h0000;

  blk_ram_slv #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .CLR_ON_RST(1)) u1 (.CLK(clk), .RST_N(rst_n), .bus(b1));
  blk_ram_slv #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2), .CLR_ON_RST(1)) u2 (.CLK(clk), .RST_N(rst_n), .bus(b2));
  blk_ram_slv #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .CLR_ON_RST(0)) u3 (.CLK(clk), .RST_N(rst_n), .bus(b3));

  task automatic idle();
    b1.READ  = 1'b0;
    b1.WRITE = 1'b0;
  endtask

  task automatic cmd(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
    b1.READ  = rd;
    b1.WRITE = wr;
    b1.ADDR  = a;
    b1.DATAI = d;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    cmd(0, 0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    n_tests++; if (b1.DATAO !== 16'h0000) begin n_fail++; $display("FAIL rst_datao: got %h want 0000", b1.DATAO); end
    n_tests++; if (b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid: got %b want 0", b1.DVALID); end
    n_tests++; if (b1.ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", b1.ERR); end
    n_tests++; if (b1.BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_busy1: got %b want 1", b1.BUSY); end
    n_tests++; if (b2.BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_busy2: got %b want 1", b2.BUSY); end
    n_tests++; if (b3.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy_noclr: got %b want 0", b3.BUSY); end
    rst_n = 1'b1;
    n = 0;
    while (b1.BUSY === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    n_tests++; if (n != 256) begin n_fail++; $display("FAIL clear_len: got %0d cycles want 256", n); end
    n_tests++; if (b3.BUSY !== 1'b0) begin n_fail++; $display("FAIL noclr_busy: got %b want 0", b3.BUSY); end
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    cmd(1, 0, 8'h55, 16'h0000);
    @(negedge clk); idle();
    n_tests++; if (b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL rd55_early: got dvalid %b want 0", b1.DVALID); end
    @(negedge clk);
    n_tests++; if (b1.DVALID !== 1'b1 || b1.DATAO !== mem_m[8'h55]) begin n_fail++; $display("FAIL rd55_lat1: got %b/%h want 1/%h", b1.DVALID, b1.DATAO, mem_m[8'h55]); end
    n_tests++; if (b2.DVALID !== 1'b0) begin n_fail++; $display("FAIL rd55_lat2_early: got dvalid %b want 0", b2.DVALID); end
    @(negedge clk);
    n_tests++; if (b2.DVALID !== 1'b1 || b2.DATAO !== mem_m[8'h55]) begin n_fail++; $display("FAIL rd55_lat2: got %b/%h want 1/%h", b2.DVALID, b2.DATAO, mem_m[8'h55]); end
    n_tests++; if (b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL rd55_pulse: got dvalid %b want 0", b1.DVALID); end
  endtask

  task automatic test_write_read();
    cmd(0, 1, 8'h3C, 16'hBEEF);
    mem_m[8'h3C] = 16'hBEEF;
    @(negedge clk);
    n_tests++; if (b1.ERR !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", b1.ERR); end
    cmd(1, 0, 8'h3C, 16'h0000);
    @(negedge clk); idle();
    n_tests++; if (b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL wr_nodvalid: got %b want 0", b1.DVALID); end
    @(negedge clk);
    n_tests++; if (b1.DVALID !== 1'b1 || b1.DATAO !== 16'hBEEF) begin n_fail++; $display("FAIL raw_lat1: got %b/%h want 1/beef", b1.DVALID, b1.DATAO); end
    n_tests++; if (b2.DVALID !== 1'b0) begin n_fail++; $display("FAIL raw_lat2_early: got %b want 0", b2.DVALID); end
    @(negedge clk);
    n_tests++; if (b2.DVALID !== 1'b1 || b2.DATAO !== 16'hBEEF) begin n_fail++; $display("FAIL raw_lat2: got %b/%h want 1/beef", b2.DVALID, b2.DATAO); end
  endtask

  task automatic test_back_to_back();
    logic        ev1, ev2;
    logic [15:0] ed1, ed2;
    for (int i = 0; i < 13; i++) begin
      if (i < 4) begin
        cmd(0, 1, 8'(i), 16'(32'h1111 * (i + 1)));
        mem_m[i] = 16'(32'h1111 * (i + 1));
      end else if (i < 8) cmd(1, 0, 8'(i - 4), 16'h0000);
      else idle();
      @(negedge clk);
      ev1 = (i >= 5 && i <= 8);
      ed1 = 16'(32'h1111 * (i - 4));
      ev2 = (i >= 6 && i <= 9);
      ed2 = 16'(32'h1111 * (i - 5));
      n_tests++; if (b1.DVALID !== ev1) begin n_fail++; $display("FAIL b2b_dv1[%0d]: got %b want %b", i, b1.DVALID, ev1); end
      if (ev1) begin n_tests++; if (b1.DATAO !== ed1) begin n_fail++; $display("FAIL b2b_d1[%0d]: got %h want %h", i, b1.DATAO, ed1); end end
      n_tests++; if (b2.DVALID !== ev2) begin n_fail++; $display("FAIL b2b_dv2[%0d]: got %b want %b", i, b2.DVALID, ev2); end
      if (ev2) begin n_tests++; if (b2.DATAO !== ed2) begin n_fail++; $display("FAIL b2b_d2[%0d]: got %h want %h", i, b2.DATAO, ed2); end end
    end
    n_tests++; if (b1.DATAO !== 16'h4444 || b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL b2b_hold1: got %h/%b want 4444/0", b1.DATAO, b1.DVALID); end
    n_tests++; if (b2.DATAO !== 16'h4444 || b2.DVALID !== 1'b0) begin n_fail++; $display("FAIL b2b_hold2: got %h/%b want 4444/0", b2.DATAO, b2.DVALID); end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin cmd(0, 1, 8'h10, 16'hAAAA); mem_m[8'h10] = 16'hAAAA; end
        1: begin cmd(1, 1, 8'h10, 16'h5555); mem_m[8'h10] = 16'h5555; end
        4: cmd(1, 0, 8'h10, 16'h0000);
        default: idle();
      endcase
      @(negedge clk);
      case (i)
        0: begin n_tests++; if (b1.ERR !== 1'b0) begin n_fail++; $display("FAIL col_preload_err: got %b want 0", b1.ERR); end end
        1: begin
          n_tests++; if (b1.ERR !== 1'b1) begin n_fail++; $display("FAIL col_err1: got %b want 1", b1.ERR); end
          n_tests++; if (b2.ERR !== 1'b1) begin n_fail++; $display("FAIL col_err2: got %b want 1", b2.ERR); end
        end
        2: begin
          n_tests++; if (b1.ERR !== 1'b0) begin n_fail++; $display("FAIL col_err_pulse: got %b want 0", b1.ERR); end
          n_tests++; if (b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL col_nodv1: got %b want 0", b1.DVALID); end
        end
        3: begin n_tests++; if (b2.DVALID !== 1'b0) begin n_fail++; $display("FAIL col_nodv2: got %b want 0", b2.DVALID); end end
        5: begin n_tests++; if (b1.DVALID !== 1'b1 || b1.DATAO !== 16'h5555) begin n_fail++; $display("FAIL col_rd1: got %b/%h want 1/5555", b1.DVALID, b1.DATAO); end end
        6: begin n_tests++; if (b2.DVALID !== 1'b1 || b2.DATAO !== 16'h5555) begin n_fail++; $display("FAIL col_rd2: got %b/%h want 1/5555", b2.DVALID, b2.DATAO); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    localparam int N = 200;
    logic        e1v [N+4];
    logic [15:0] e1d [N+4];
    logic        e2v [N+4];
    logic [15:0] e2d [N+4];
    logic        eerr[N+4];
    logic [15:0] hold1, hold2;
    logic        rd, wr;
    logic [7:0]  a;
    logic [15:0] d;
    for (int i = 0; i < N + 4; i++) begin e1v[i] = 0; e2v[i] = 0; eerr[i] = 0; e1d[i] = 0; e2d[i] = 0; end
    hold1 = 16'h5555;
    hold2 = 16'h5555;
    for (int i = 0; i < N + 3; i++) begin
      if (i < N) begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 15));
        d  = 16'($urandom);
        cmd(rd, wr, a, d);
        if (rd && !wr) begin
          e1v[i+1] = 1; e1d[i+1] = mem_m[a];
          e2v[i+2] = 1; e2d[i+2] = mem_m[a];
        end
        if (rd && wr) eerr[i] = 1;
        if (wr) mem_m[a] = d;
      end else idle();
      @(negedge clk);
      if (e1v[i]) hold1 = e1d[i];
      if (e2v[i]) hold2 = e2d[i];
      n_tests++; if (b1.DVALID !== e1v[i] || b1.DATAO !== hold1) begin n_fail++; $display("FAIL rnd_lat1[%0d]: got %b/%h want %b/%h", i, b1.DVALID, b1.DATAO, e1v[i], hold1); end
      n_tests++; if (b2.DVALID !== e2v[i] || b2.DATAO !== hold2) begin n_fail++; $display("FAIL rnd_lat2[%0d]: got %b/%h want %b/%h", i, b2.DVALID, b2.DATAO, e2v[i], hold2); end
      n_tests++; if (b1.ERR !== eerr[i]) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, b1.ERR, eerr[i]); end
    end
  endtask

  task automatic test_busy();
    int n;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cmd(0, 1, 8'h20, 16'h1234);
    @(negedge clk);
    n_tests++; if (b1.ERR !== 1'b1) begin n_fail++; $display("FAIL busy_wr_err: got %b want 1", b1.ERR); end
    n_tests++; if (b1.BUSY !== 1'b1) begin n_fail++; $display("FAIL busy_flag: got %b want 1", b1.BUSY); end
    cmd(1, 0, 8'h20, 16'h0000);
    @(negedge clk); idle();
    n_tests++; if (b2.ERR !== 1'b1) begin n_fail++; $display("FAIL busy_rd_err: got %b want 1", b2.ERR); end
    @(negedge clk);
    n_tests++; if (b1.ERR !== 1'b0) begin n_fail++; $display("FAIL busy_err_clear: got %b want 0", b1.ERR); end
    n_tests++; if (b1.DVALID !== 1'b0) begin n_fail++; $display("FAIL busy_rd_dropped: got %b want 0", b1.DVALID); end
    // Reset again part-way through the clear: it must start over at 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (b1.BUSY === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    n_tests++; if (n != 256) begin n_fail++; $display("FAIL reclear_len: got %0d cycles want 256", n); end
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    cmd(1, 0, 8'h20, 16'h0000);
    @(negedge clk); idle();
    @(negedge clk);
    n_tests++; if (b1.DVALID !== 1'b1 || b1.DATAO !== 16'h0000) begin n_fail++; $display("FAIL busy_rd20_1: got %b/%h want 1/0000", b1.DVALID, b1.DATAO); end
    @(negedge clk);
    n_tests++; if (b2.DVALID !== 1'b1 || b2.DATAO !== 16'h0000) begin n_fail++; $display("FAIL busy_rd20_2: got %b/%h want 1/0000", b2.DVALID, b2.DATAO); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    cmd(0, 1, 8'h77, 16'hCAFE);
    @(negedge clk);
    cmd(1, 0, 8'h77, 16'h0000);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    n_tests++; if (b2.DATAO !== 16'hCAFE) begin n_fail++; $display("FAIL mid_setup: got %h want cafe", b2.DATAO); end
    cmd(1, 0, 8'h77, 16'h0000);
    @(negedge clk); idle();
    rst_n = 1'b0;
    #1;
    n_tests++; if (b2.DVALID !== 1'b0 || b2.DATAO !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_out: got %b/%h want 0/0000", b2.DVALID, b2.DATAO); end
    n_tests++; if (b2.BUSY !== 1'b1 || b1.BUSY !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy: got %b%b want 11", b1.BUSY, b2.BUSY); end
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (b2.DVALID !== 1'b0) begin n_fail++; $display("FAIL mid_rst_nodv: got %b want 0", b2.DVALID); end
    end
    rst_n = 1'b1;
    n = 0;
    while (b2.BUSY === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    n_tests++; if (n != 256) begin n_fail++; $display("FAIL mid_clear_len: got %0d cycles want 256", n); end
    cmd(1, 0, 8'h77, 16'h0000);
    @(negedge clk); idle();
    @(negedge clk);
    n_tests++; if (b1.DVALID !== 1'b1 || b1.DATAO !== 16'h0000) begin n_fail++; $display("FAIL mid_cleared1: got %b/%h want 1/0000", b1.DVALID, b1.DATAO); end
    @(negedge clk);
    n_tests++; if (b2.DVALID !== 1'b1 || b2.DATAO !== 16'h0000) begin n_fail++; $display("FAIL mid_cleared2: got %b/%h want 1/0000", b2.DVALID, b2.DATAO); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_random();
    test_busy();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/blk_ram_slv.md
# blk_ram_slv

Single-port block-RAM responder for the block-RAM bus: the slave end that accepts READ/WRITE commands from the master side and returns read data on DATAO. It holds the storage array, clears it after reset, and returns read data with a fixed, parameterised latency. It is the behavioural target the master-side interface connects to at the slave end of the RAM bus.

## Interface
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- DATA_W, 16, data word width
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- CLR_ON_RST, 1, 1 = zero the whole array after reset; 0 = no clear, contents undefined
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- READ  in  1  read command, sampled each rising edge
- WRITE  in  1  write command, sampled each rising edge
- ADDR  in  ADDR_W  command address
- DATAI  in  DATA_W  write data
- DATAO  out  DATA_W  read data, held between reads
- DVALID  out  1  one-cycle pulse per returned read word
- BUSY  out  1  array clear in progress, commands refused
- ERR  out  1  one-cycle pulse when a command is dropped or collides

## Operation
- Clock is CLK; reset is RST_N, asynchronous assert, active-low. Release is synchronous to CLK.
- Reset values: DATAO = 0, DVALID = 0, ERR = 0, clear counter = 0. BUSY = 1 if CLR_ON_RST, else 0.
- State machine:
  - CLEAR: writes 0 to address = counter each cycle, then increments the counter. After address 2**ADDR_W-1 is written, goes to READY and BUSY falls. Lasts exactly 2**ADDR_W cycles after reset release.
  - READY: serves commands.
  - With CLR_ON_RST = 0, the block enters READY directly from reset.
- Write in READY (WRITE=1, READ=0): mem[ADDR] <= DATAI at the sampling edge. No DVALID.
- Read in READY (READ=1, WRITE=0):
  - mem[ADDR] is captured into an RD_LAT-deep pipeline together with a valid bit.
  - The pipeline output drives DATAO and DVALID.
  - DATAO updates only when DVALID is asserted; otherwise it holds its last value.
- Back-to-back reads: one read accepted per cycle, fully pipelined, and returned in order.
- Read after write to the same address in the next cycle returns the new data (write-first across cycles).
- Collision (READ=1 and WRITE=1 in the same cycle): the write is performed, the read is discarded (no DVALID), and ERR pulses for 1 cycle.
- Command while BUSY: ignored, with no array or pipeline effect. ERR pulses for 1 cycle per cycle with READ or WRITE high.
- ADDR is always in range (full decode); there is no wrap logic beyond natural ADDR_W width.
- Reset mid-operation:
  - In-flight reads are discarded and DVALID is forced to 0 immediately.
  - The clear counter returns to 0 and CLEAR restarts from address 0 (if CLR_ON_RST).
  - Array contents are not otherwise reset.

## Timing
- Write: command at edge N, data visible to a read sampled at edge N+1.
- Read: command at edge N, DATAO/DVALID valid after edge N+RD_LAT, for exactly one cycle of DVALID.
- Sustained read throughput: 1 word/cycle. No gaps are inserted between consecutive DVALID pulses for consecutive READ cycles.
- ERR: asserted after the edge that samples the offending command, cleared next edge unless it recurs.
- BUSY falls after the edge writing the last address. A command sampled at the next edge is accepted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset clear (defaults, CLR_ON_RST=1): release RST_N, then BUSY is high for exactly 256 cycles. Then READ ADDR=0x55 returns DATAO=0x0000 with DVALID 1 cycle later.
- Write/read: WRITE ADDR=0x3C DATAI=0xBEEF, next cycle READ 0x3C. Required: DVALID and DATAO=0xBEEF at N+1 for RD_LAT=1, and at N+2 for RD_LAT=2.
- Back-to-back:
  - Write 0x1111/0x2222/0x3333/0x4444 to 0x00–0x03.
  - Then READ 0x00–0x03 on four consecutive cycles.
  - Required: four consecutive DVALID cycles carrying the data in order.
  - DATAO holds 0x4444 afterwards with DVALID=0.
- Collision: preload 0x10=0xAAAA. READ=WRITE=1 at 0x10 with DATAI=0x5555. Required: ERR pulses once, no DVALID, and a later read of 0x10 returns 0x5555.
- Command during BUSY: WRITE 0x20=0x1234 at cycle 5 after reset release. Required: ERR pulse, and a read of 0x20 after BUSY falls returns 0x0000.
- Reset mid-read: issue READ with RD_LAT=2 and assert RST_N low one cycle later. Required: no DVALID, DATAO=0, BUSY=1, and the clear restarts at address 0.
